// File: rtl/ram_op_sequencer_if.sv
// Command handshake and operand-RAM port bundle for ram_op_sequencer.
// master = command source / RAM side, slave = the sequencer.
interface ram_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_src1;
  logic [3:0] cmd_src2;
  logic [3:0] cmd_dst;
  logic [3:0] cmd_imm;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [3:0] ram_data;
  logic [3:0] ram_addrop1;
  logic [3:0] ram_addrop2;
  logic [3:0] ram_rdataop1;
  logic [3:0] ram_rdataop2;
  logic       done;
  logic       flag;

  modport master (
    output cmd_valid, cmd_op, cmd_src1, cmd_src2,
    output cmd_dst, cmd_imm,
    output ram_rdataop1, ram_rdataop2,
    input  cmd_ready, ram_we, ram_addr, ram_data,
    input  ram_addrop1, ram_addrop2, done, flag
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src1, cmd_src2,
    input  cmd_dst, cmd_imm,
    input  ram_rdataop1, ram_rdataop2,
    output cmd_ready, ram_we, ram_addr, ram_data,
    output ram_addrop1, ram_addrop2, done, flag
  );
endinterface

// File: rtl/ram_op_sequencer.sv
// Command sequencer for the 16x4 operand RAM: READ, EXEC, WRITE per op.
// Define SEQ_SAT_EN to saturate ADD/SUB instead of wrapping.
module ram_op_sequencer (
  input logic          clock,
  input logic          reset_n,
  ram_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, READ, EXEC, WRITE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD, OP_SUB, OP_AND, OP_LDI
  } op_t;

  state_t     state;
  op_t        op;
  logic [3:0] result;
  logic       carry;

  logic [4:0] sum;
  logic [4:0] diff;
  logic [3:0] alu_res;
  logic       alu_c;

  assign bus.ram_data = result;

  always_comb begin
    sum     = {1'b0, bus.ram_rdataop1} + {1'b0, bus.ram_rdataop2};
    diff    = {1'b0, bus.ram_rdataop1} - {1'b0, bus.ram_rdataop2};
    alu_res = bus.ram_rdataop1 & bus.ram_rdataop2;
    alu_c   = 1'b0;
    unique case (1'b1)
      op == OP_ADD: begin
        alu_c = sum[4];
`ifdef SEQ_SAT_EN
        alu_res = sum[4] ? 4'hF : sum[3:0];
`else
        alu_res = sum[3:0];
`endif
      end
      op == OP_SUB: begin
        // bit 4 of the 5-bit difference is the borrow
        alu_c = diff[4];
`ifdef SEQ_SAT_EN
        alu_res = diff[4] ? 4'h0 : diff[3:0];
`else
        alu_res = diff[3:0];
`endif
      end
      default: begin
        alu_res = bus.ram_rdataop1 & bus.ram_rdataop2;
        alu_c   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      op              <= OP_ADD;
      result          <= 4'h0;
      carry           <= 1'b0;
      bus.cmd_ready   <= 1'b0;
      bus.ram_we      <= 1'b0;
      bus.ram_addr    <= 4'h0;
      bus.ram_addrop1 <= 4'h0;
      bus.ram_addrop2 <= 4'h0;
      bus.done        <= 1'b0;
      bus.flag        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.cmd_valid && bus.cmd_ready) begin
            op            <= op_t'(bus.cmd_op);
            bus.ram_addr  <= bus.cmd_dst;
            bus.cmd_ready <= 1'b0;
            if (op_t'(bus.cmd_op) == OP_LDI) begin
              state      <= WRITE;
              result     <= bus.cmd_imm;
              carry      <= 1'b0;
              bus.ram_we <= 1'b1;
            end else begin
              state           <= READ;
              bus.ram_addrop1 <= bus.cmd_src1;
              bus.ram_addrop2 <= bus.cmd_src2;
            end
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        READ: begin
          state <= EXEC;
        end
        EXEC: begin
          state      <= WRITE;
          result     <= alu_res;
          carry      <= alu_c;
          bus.ram_we <= 1'b1;
        end
        WRITE: begin
          state         <= IDLE;
          bus.ram_we    <= 1'b0;
          bus.done      <= 1'b1;
          bus.flag      <= carry;
          bus.cmd_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/ram_op_sequencer.md
# ram_op_sequencer

Command-driven controller that sequences the 16x4 operand RAM (one write/read address, two operand read addresses, synchronous reads when not writing). Accepts one register-to-register command at a time over a valid/ready handshake, issues the operand reads, computes a 4-bit result, and writes it back to the destination address. It sits between the instruction source and the operand RAM, and is the only master driving the RAM ports.

## Interface
Parameters: none; all widths are fixed at 4-bit data and 4-bit address to match the operand RAM.

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 LOADI
- cmd_src1  in  4  first operand address
- cmd_src2  in  4  second operand address
- cmd_dst  in  4  destination address
- cmd_imm  in  4  immediate value; used by LOADI only
- ram_we  out  1  RAM write enable
- ram_addr  out  4  RAM write address; always cmd_dst as latched
- ram_data  out  4  RAM write data; the result register
- ram_addrop1  out  4  operand 1 read address
- ram_addrop2  out  4  operand 2 read address
- ram_rdataop1  in  4  operand 1 read data from the RAM
- ram_rdataop2  in  4  operand 2 read data from the RAM
- done  out  1  one-cycle pulse; command committed
- flag  out  1  carry or borrow of the last command; held until the next commit

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op, src1, src2, dst and imm.
  - LOADI goes to WRITE with result=imm. Every other opcode goes to READ.
- READ:
  - ram_we=0; ram_addrop1=src1, ram_addrop2=src2.
  - The RAM captures the operands at the end of this cycle.
- EXEC:
  - The ram_rdataop1/ram_rdataop2 inputs are valid.
  - Compute the result and carry, and register them at the end of the cycle.
- WRITE:
  - ram_we=1, ram_addr=dst, ram_data=result.
  - The RAM writes at the end of the cycle.
  - Next state is IDLE, with done=1 and flag updated in that IDLE cycle.
- Arithmetic (4-bit, unsigned):
  - ADD: result = (a+b)[3:0]; flag = carry out of bit 3.
  - SUB: result = (a-b)[3:0]; flag = 1 iff a<b (borrow).
  - AND: result = a&b; flag = 0.
  - LOADI: result = imm; flag = 0.
- Commands presented outside IDLE are not accepted. cmd_valid must stay high with its fields stable until accepted.
- src1==src2 is legal; both ports read the same word.
- dst equal to a source is legal. The write happens after the read, so the old value is used.
- Reset:
  - Asynchronous assertion forces IDLE immediately.
  - While reset_n is low: ram_we=0, cmd_ready=0, done=0, flag=0, and result, ram_data, ram_addr, ram_addrop1, ram_addrop2 = 0.
  - A reset that lands mid-command aborts it; no write occurs unless WRITE already reached its clock edge.
  - cmd_ready rises in the first cycle after reset_n deasserts.

## Timing
- cmd_ready, done and all RAM-side outputs are decoded from registered state; there are no combinational paths from cmd_* to outputs.
- ALU command accepted at edge E0:
  - READ in E0..E1, EXEC in E1..E2, WRITE in E2..E3.
  - done=1 and cmd_ready=1 in E3..E4.
  - 4-cycle accept-to-done latency.
- LOADI accepted at E0: WRITE in E0..E1, done in E1..E2.
- Back-to-back throughput:
  - A new command can be accepted at the same edge that ends the done cycle, giving one ALU command per 4 cycles.
  - A command following a write reads the committed value; no forwarding is needed.
- ram_we is high for exactly one cycle per command.
- ram_we is never high in READ or EXEC, because the RAM only reads when ram_we=0.

## Configuration
- `SEQ_SAT_EN` defined:
  - ADD saturates to 4'hF on carry.
  - SUB clamps to 4'h0 on borrow.
  - flag still reports the carry or borrow.
- `SEQ_SAT_EN` undefined: ADD and SUB wrap modulo 16.
- AND and LOADI are unaffected by the macro.

## Test plan
- Reset:
  - Hold reset_n=0 for 3 cycles, then release.
  - During reset, all outputs are 0.
  - cmd_ready=1 one cycle after release.
  - ram_we stays 0.
- LOADI:
  - LOADI dst=3, imm=9.
  - ram_we=1 with ram_addr=3, ram_data=9 for one cycle.
  - done is pulsed one cycle later; flag=0.
- ADD with overflow:
  - Preload mem[1]=12 and mem[2]=7, then ADD src1=1, src2=2, dst=4.
  - Without the macro: mem[4]=3, flag=1.
  - With `SEQ_SAT_EN`: mem[4]=15, flag=1.
  - done appears 4 cycles after accept.
- SUB with borrow, in place:
  - mem[5]=2, mem[6]=5; SUB src1=5, src2=6, dst=5.
  - mem[5]=13 (or 0 with `SEQ_SAT_EN`); flag=1.
  - Operand read before the write: the old value 2 is used.
- Back-to-back AND:
  - Keep cmd_valid asserted with two queued commands; the second reads the first's dst.
  - Second accepted at the edge ending the first's done cycle.
  - Second sees the updated value.
- Abort:
  - Assert reset_n=0 during EXEC of an ADD to dst=7.
  - mem[7] is unchanged; ram_we never goes high; done is not pulsed.
